regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
- Parametrised successor to the core's integer register file.
- Adds configurable width, depth and read-port count, with x0 hardwired to zero.
- Has two write ports: port A is pipeline writeback; port B is writeback from the multi-cycle multiply/divide unit.
- Has same-cycle write-to-read bypass, and a per-register busy scoreboard so issue logic can stall on results still pending from the multiply/divide unit.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of registers (power of two, >=2); AW = clog2(NREG)
NRD, 2, number of read ports
ZERO_REG, 1, 1 = register 0 reads zero and ignores writes/scoreboard sets
BYPASS, 1, 1 = read ports see same-cycle writes; 0 = read ports see stored state only

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
rd_addr  in  NRD*AW  read addresses, port i at [i*AW +: AW]
rd_data  out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
rd_busy  out  NRD  scoreboard busy bit of each read address
wa_en  in  1  port A write enable
wa_addr  in  AW  port A write address
wa_data  in  XLEN  port A write data
wb_en  in  1  port B write enable; also clears the busy bit of wb_addr
wb_addr  in  AW  port B write address
wb_data  in  XLEN  port B write data
sb_set_en  in  1  mark sb_set_addr busy (long-latency op issued)
sb_set_addr  in  AW  register to mark busy
sb_flush  in  1  clear all busy bits
busy_any  out  1  OR of all busy bits (drain indicator)
err  out  1  sticky protocol-error flag

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous, active-low; assertion immediately clears all registers, all busy bits and err.
- Outputs after reset: rd_data=0, rd_busy=0, busy_any=0, err=0.
- Writes: take effect on the clk rising edge.
- Write collision: if wa_en and wb_en target the same address in one cycle, port A's data is stored (younger instruction wins) and err is set.
- Register 0 with ZERO_REG=1: writes are dropped, reads return 0, sb_set to register 0 is ignored, and no err is raised for register 0 collisions.
- Reads are combinational, with zero latency.
  - BYPASS=1: if wa_en and wa_addr==rd_addr[i], return wa_data. Otherwise, if wb_en and wb_addr==rd_addr[i], return wb_data. Otherwise return stored data.
  - BYPASS=0: return stored data only.
- Scoreboard busy bits, per register, evaluated at each edge in this priority order:
  1. sb_flush clears all bits.
  2. Otherwise, wb_en clears bit[wb_addr].
  3. Then sb_set_en sets bit[sb_set_addr].
  - Consequence: a set and a clear to the same address in one cycle leaves the bit set (new issue while the old op completes).
  - sb_flush in the same cycle as sb_set_en: the flush wins and the set is dropped.
- Scoreboard errors (each sets err):
  - sb_set_en to an address that is already busy and not cleared by wb_en that cycle.
  - wb_en to an address whose busy bit is 0 and that is not being flushed that cycle.
- rd_busy[i]:
  - Equals busy[rd_addr[i]], except it reads 0 when wb_en clears that address in the same cycle (when BYPASS=1).
  - A same-cycle sb_set becomes visible on the next cycle only.
- Port A does not touch busy bits. A port A write to a busy register is legal (stale-result overwrite) and raises no err.
- busy_any: combinational OR of the stored busy bits.
- err: stays set until rst.
- Reset mid-operation: all state clears. A port B write arriving after reset writes data normally and also raises err, because its busy bit is 0.

Decomposition:
- Shared package: XLEN, NREG, AW, and the rd_addr/rd_data slice-index helper functions.
- Sub-module scoreboard_bits owns the busy vector, the set/clear/flush priority, busy_any and the scoreboard error terms.
- Data array, bypass muxes and collision detect stay in regfile_sb.

Test Plan:
- Apply reset, then read all 32 addresses on both ports → all return 0.
  - Assert rst low mid-run after writes → outputs return to 0 asynchronously, before the next edge.
- Port A write x5=0xDEADBEEF with rd_addr[0]=5 in the same cycle → rd_data[0]=0xDEADBEEF the same cycle (BYPASS=1), and it persists after the edge.
  - Write x0=0x1234 → reads still 0, err=0.
- Port A and port B write x7 in the same cycle (A=0x11, B=0x22) → the bypass read and the stored value are 0x11, and err=1 from the next cycle onward.
- sb_set x9 → the next cycle gives rd_busy=1 and busy_any=1.
  - Port B write x9=0xCAFE → rd_busy drops to 0 the same cycle, and rd_data=0xCAFE.
  - Next cycle: busy_any=0, err=0.
- Scoreboard priority and errors:
  - sb_set x3 and port B write x3 in one cycle, with x3 already busy → x3 stays busy, err=0.
  - sb_set on busy x4 with no port B write → err=1.
  - sb_flush together with sb_set x6 → all bits 0.
  - A later port B write to x6 → data written, err=1.

Source files
------------

// File: rtl/regfile_sb_pkg.sv
// Shared constants and packed-port slice helpers for the scoreboarded register file.
package regfile_sb_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = $clog2(NREG);
  localparam int NRD  = 2;

  function automatic int addr_lo(input int port, input int aw);
    return port * aw;
  endfunction

  function automatic int data_lo(input int port, input int xlen);
    return port * xlen;
  endfunction
endpackage

// File: rtl/regfile_sb_if.sv
// Read/write/scoreboard bundle between issue/writeback logic and regfile_sb.
interface regfile_sb_if #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int NRD  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                wa_en;
  logic [AW-1:0]       wa_addr;
  logic [XLEN-1:0]     wa_data;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                sb_set_en;
  logic [AW-1:0]       sb_set_addr;
  logic                sb_flush;
  logic                busy_any;
  logic                err;

  modport master (
    output rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set_en, sb_set_addr, sb_flush,
    input  rd_data, rd_busy, busy_any, err
  );

  modport slave (
    input  rd_addr, wa_en, wa_addr, wa_data, wb_en, wb_addr, wb_data,
           sb_set_en, sb_set_addr, sb_flush,
    output rd_data, rd_busy, busy_any, err
  );
endinterface

// File: rtl/regfile_sb_scoreboard_bits.sv
// Per-register busy bits: flush > writeback-clear > set, plus per-port busy lookup and error terms.
module scoreboard_bits
  import regfile_sb_pkg::addr_lo;
#(
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wb_en,
  input  logic [AW-1:0]     i_wb_addr,
  input  logic              i_set_en,
  input  logic [AW-1:0]     i_set_addr,
  input  logic              i_flush,
  input  logic [NRD*AW-1:0] i_rd_addr,
  output logic [NRD-1:0]    o_rd_busy,
  output logic              o_busy_any,
  output logic              o_sb_err
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;
  logic            w_set_ok;

  assign w_set_ok = i_set_en && !((ZERO_REG != 0) && (i_set_addr == '0));

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flush) begin
      w_busy_nxt = '0;
    end else begin
      if (i_wb_en)  w_busy_nxt[i_wb_addr]  = 1'b0;
      if (w_set_ok) w_busy_nxt[i_set_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_busy <= '0;
    else        r_busy <= w_busy_nxt;
  end

  // Double issue to a pending register, or a completion nobody was waiting for.
  assign o_sb_err = (w_set_ok && r_busy[i_set_addr] && !(i_wb_en && (i_wb_addr == i_set_addr)))
                 || (i_wb_en && !r_busy[i_wb_addr] && !i_flush);

  assign o_busy_any = |r_busy;

  for (genvar g = 0; g < NRD; g++) begin : g_port
    logic [AW-1:0] w_ra;
    assign w_ra = i_rd_addr[addr_lo(g, AW) +: AW];
    assign o_rd_busy[g] = r_busy[w_ra] && !((BYPASS != 0) && i_wb_en && (i_wb_addr == w_ra));
  end
endmodule

// File: rtl/regfile_sb.sv
// Parametrised integer register file: two write ports, bypassed reads, busy scoreboard, sticky err.
module regfile_sb
  import regfile_sb_pkg::addr_lo;
  import regfile_sb_pkg::data_lo;
#(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREG)
) (
  input logic         clk,
  input logic         rst_n,
  regfile_sb_if.slave bus
);
  logic [XLEN-1:0] r_mem [NREG];
  logic            r_err;
  logic            w_wa_ok, w_wb_ok, w_col_err, w_sb_err;

  assign w_wa_ok   = bus.wa_en && !((ZERO_REG != 0) && (bus.wa_addr == '0));
  assign w_wb_ok   = bus.wb_en && !((ZERO_REG != 0) && (bus.wb_addr == '0));
  assign w_col_err = bus.wa_en && bus.wb_en && (bus.wa_addr == bus.wb_addr)
                  && !((ZERO_REG != 0) && (bus.wa_addr == '0));

  // Port A is the younger instruction, so its write is issued last and wins a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NREG; k++) r_mem[k] <= '0;
    end else begin
      if (w_wb_ok) r_mem[bus.wb_addr] <= bus.wb_data;
      if (w_wa_ok) r_mem[bus.wa_addr] <= bus.wa_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_err <= 1'b0;
    else        r_err <= r_err | w_col_err | w_sb_err;
  end

  assign bus.err = r_err;

  for (genvar g = 0; g < NRD; g++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_rd;
    assign w_ra = bus.rd_addr[addr_lo(g, AW) +: AW];
    always_comb begin
      w_rd = r_mem[w_ra];
      if (BYPASS != 0) begin
        if (bus.wa_en && (bus.wa_addr == w_ra))      w_rd = bus.wa_data;
        else if (bus.wb_en && (bus.wb_addr == w_ra)) w_rd = bus.wb_data;
      end
      if ((ZERO_REG != 0) && (w_ra == '0)) w_rd = '0;
    end
    assign bus.rd_data[data_lo(g, XLEN) +: XLEN] = w_rd;
  end

  scoreboard_bits #(
    .NREG(NREG), .NRD(NRD), .ZERO_REG(ZERO_REG), .BYPASS(BYPASS)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wb_en   (bus.wb_en),
    .i_wb_addr (bus.wb_addr),
    .i_set_en  (bus.sb_set_en),
    .i_set_addr(bus.sb_set_addr),
    .i_flush   (bus.sb_flush),
    .i_rd_addr (bus.rd_addr),
    .o_rd_busy (bus.rd_busy),
    .o_busy_any(bus.busy_any),
    .o_sb_err  (w_sb_err)
  );
endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector table, async-reset sequence and randomized run against a spec-level model.
module tb_regfile_sb;
  localparam int XLEN = 32, NREG = 32, NRD = 2, AW = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regfile_sb_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) bus ();
  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .ZERO_REG(1), .BYPASS(1))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic wa_en; logic [4:0] wa_a; logic [31:0] wa_d;
    logic wb_en; logic [4:0] wb_a; logic [31:0] wb_d;
    logic set_en; logic [4:0] set_a; logic flush;
    logic [4:0] ra0, ra1;
  } in_t;

  typedef struct {
    bit rst; in_t in;
    logic [31:0] d0, d1; logic [1:0] bsy; logic any, err;
  } tv_t;

  int n_vec = 0, n_miss = 0;
  logic [31:0] m_mem [NREG];
  bit          m_busy [NREG];
  bit          m_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic in_t mk_in(logic wae, logic [4:0] waa, logic [31:0] wad,
                                logic wbe, logic [4:0] wba, logic [31:0] wbd,
                                logic se, logic [4:0] sa, logic fl,
                                logic [4:0] r0, logic [4:0] r1);
    in_t x;
    x.wa_en = wae; x.wa_a = waa; x.wa_d = wad;
    x.wb_en = wbe; x.wb_a = wba; x.wb_d = wbd;
    x.set_en = se; x.set_a = sa; x.flush = fl;
    x.ra0 = r0; x.ra1 = r1;
    return x;
  endfunction

  function automatic tv_t mk_tv(bit r, in_t x, logic [31:0] d0, logic [31:0] d1,
                                logic [1:0] b, logic any, logic err);
    tv_t t;
    t.rst = r; t.in = x; t.d0 = d0; t.d1 = d1; t.bsy = b; t.any = any; t.err = err;
    return t;
  endfunction

  task automatic apply(input in_t x);
    bus.wa_en = x.wa_en; bus.wa_addr = x.wa_a; bus.wa_data = x.wa_d;
    bus.wb_en = x.wb_en; bus.wb_addr = x.wb_a; bus.wb_data = x.wb_d;
    bus.sb_set_en = x.set_en; bus.sb_set_addr = x.set_a; bus.sb_flush = x.flush;
    bus.rd_addr = {x.ra1, x.ra0};
  endtask

  task automatic model_clear();
    for (int k = 0; k < NREG; k++) begin m_mem[k] = '0; m_busy[k] = 1'b0; end
    m_err = 1'b0;
  endtask

  // Pulse reset mid-cycle with idle inputs.
  task automatic do_reset();
    @(posedge clk); #1;
    apply(mk_in(0,0,0, 0,0,0, 0,0,0, 0,0));
    rst_n = 1'b0; #2; rst_n = 1'b1;
    model_clear();
  endtask

  task automatic model_edge(input in_t x);
    bit col, se, ce;
    col = x.wa_en && x.wb_en && (x.wa_a == x.wb_a) && (x.wa_a != 0);
    se  = x.set_en && (x.set_a != 0) && m_busy[x.set_a] && !(x.wb_en && x.wb_a == x.set_a);
    ce  = x.wb_en && !m_busy[x.wb_a] && !x.flush;
    if (col || se || ce) m_err = 1'b1;
    if (x.wb_en && x.wb_a != 0) m_mem[x.wb_a] = x.wb_d;
    if (x.wa_en && x.wa_a != 0) m_mem[x.wa_a] = x.wa_d;
    if (x.flush) begin
      for (int k = 0; k < NREG; k++) m_busy[k] = 1'b0;
    end else begin
      if (x.wb_en) m_busy[x.wb_a] = 1'b0;
      if (x.set_en && x.set_a != 0) m_busy[x.set_a] = 1'b1;
    end
  endtask

  function automatic logic [31:0] exp_rd(in_t x, logic [4:0] ra);
    if (ra == 0) return '0;
    if (x.wa_en && x.wa_a == ra) return x.wa_d;
    if (x.wb_en && x.wb_a == ra) return x.wb_d;
    return m_mem[ra];
  endfunction

  function automatic logic exp_bsy(in_t x, logic [4:0] ra);
    return m_busy[ra] && !(x.wb_en && x.wb_a == ra);
  endfunction

  function automatic logic exp_any();
    logic a = 1'b0;
    for (int k = 0; k < NREG; k++) a |= m_busy[k];
    return a;
  endfunction

  function automatic logic [4:0] raddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  tv_t tv [$];

  initial begin
    in_t x;
    // group 1: bypass, x0, scoreboard set/clear, priority, flush
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 0,5), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(1,5,32'hDEADBEEF,0,0,0,        0,0,0, 5,0), 32'hDEADBEEF,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 5,5), 32'hDEADBEEF,32'hDEADBEEF, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(1,0,32'h1234,   0,0,0,        0,0,0, 0,0), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 0,5), 0,32'hDEADBEEF, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        1,9,0, 9,9), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 9,5), 0,32'hDEADBEEF, 2'b01,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          1,9,32'hCAFE, 0,0,0, 9,9), 32'hCAFE,32'hCAFE, 2'b00,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 9,0), 32'hCAFE,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        1,3,0, 3,3), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          1,3,32'h33,   1,3,0, 3,3), 32'h33,32'h33, 2'b00,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 3,3), 32'h33,32'h33, 2'b11,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        1,6,1, 6,3), 0,32'h33, 2'b10,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 6,3), 0,32'h33, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          1,6,32'h66,   0,0,0, 6,6), 32'h66,32'h66, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 6,0), 32'h66,0, 2'b00,0,1));
    // group 2: double issue to busy x4
    tv.push_back(mk_tv(1, mk_in(0,0,0,          0,0,0,        1,4,0, 4,4), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        1,4,0, 4,4), 0,0, 2'b11,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 4,0), 0,0, 2'b01,1,1));
    // group 3: A/B collision on pending x7
    tv.push_back(mk_tv(1, mk_in(0,0,0,          0,0,0,        1,7,0, 7,7), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(1,7,32'h11,     1,7,32'h22,   0,0,0, 7,7), 32'h11,32'h11, 2'b00,1,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 7,0), 32'h11,0, 2'b00,0,1));
    // group 4: x0 ignores set and write
    tv.push_back(mk_tv(1, mk_in(1,0,32'h55,     0,0,0,        1,0,0, 0,0), 0,0, 2'b00,0,0));
    tv.push_back(mk_tv(0, mk_in(0,0,0,          0,0,0,        0,0,0, 0,0), 0,0, 2'b00,0,0));

    apply(mk_in(0,0,0, 0,0,0, 0,0,0, 0,0));
    model_clear();
    #12 rst_n = 1'b1;

    // after reset every address reads zero on both ports
    for (int a = 0; a < NREG; a++) begin
      bus.rd_addr = {5'(a), 5'(a)};
      #1;
      chk("rst_rd0", bus.rd_data[31:0], 0);
      chk("rst_rd1", bus.rd_data[63:32], 0);
    end
    chk("rst_busy", {30'b0, bus.rd_busy}, 0);
    chk("rst_any", {31'b0, bus.busy_any}, 0);
    chk("rst_err", {31'b0, bus.err}, 0);

    foreach (tv[i]) begin
      if (tv[i].rst) do_reset();
      @(posedge clk); #1;
      apply(tv[i].in);
      #3;
      chk($sformatf("tv%0d_d0", i), bus.rd_data[31:0], tv[i].d0);
      chk($sformatf("tv%0d_d1", i), bus.rd_data[63:32], tv[i].d1);
      chk($sformatf("tv%0d_bsy", i), {30'b0, bus.rd_busy}, {30'b0, tv[i].bsy});
      chk($sformatf("tv%0d_any", i), {31'b0, bus.busy_any}, {31'b0, tv[i].any});
      chk($sformatf("tv%0d_err", i), {31'b0, bus.err}, {31'b0, tv[i].err});
    end

    // asynchronous reset in mid-cycle, then a port B write to a now-idle register
    do_reset();
    @(posedge clk); #1;
    apply(mk_in(1,10,32'hA5A5, 0,0,0, 1,11,0, 10,11));
    @(posedge clk); #1;
    apply(mk_in(0,0,0, 0,0,0, 0,0,0, 10,11));
    #1;
    chk("pre_rst_d0", bus.rd_data[31:0], 32'hA5A5);
    chk("pre_rst_any", {31'b0, bus.busy_any}, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_d0", bus.rd_data[31:0], 0);
    chk("async_rst_bsy", {30'b0, bus.rd_busy}, 0);
    chk("async_rst_any", {31'b0, bus.busy_any}, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    apply(mk_in(0,0,0, 1,10,32'hBEEF, 0,0,0, 10,11));
    @(posedge clk); #1;
    apply(mk_in(0,0,0, 0,0,0, 0,0,0, 10,11));
    #1;
    chk("post_rst_wb_d0", bus.rd_data[31:0], 32'hBEEF);
    chk("post_rst_wb_err", {31'b0, bus.err}, 1);

    // randomized run against the model, with periodic resets
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c % 120 == 119) do_reset();
      x.wa_en = ($urandom_range(0, 1) == 1); x.wa_a = raddr(); x.wa_d = $urandom;
      x.wb_en = ($urandom_range(0, 9) < 4);  x.wb_a = raddr(); x.wb_d = $urandom;
      for (int t = 0; t < 6 && !m_busy[x.wb_a]; t++) x.wb_a = raddr();
      x.set_en = ($urandom_range(0, 9) < 3); x.set_a = raddr();
      x.flush = ($urandom_range(0, 29) == 0);
      x.ra0 = raddr(); x.ra1 = raddr();
      @(posedge clk); #1;
      apply(x);
      #3;
      chk("rnd_d0", bus.rd_data[31:0], exp_rd(x, x.ra0));
      chk("rnd_d1", bus.rd_data[63:32], exp_rd(x, x.ra1));
      chk("rnd_bsy", {30'b0, bus.rd_busy}, {30'b0, exp_bsy(x, x.ra1), exp_bsy(x, x.ra0)});
      chk("rnd_any", {31'b0, bus.busy_any}, {31'b0, exp_any()});
      chk("rnd_err", {31'b0, bus.err}, {31'b0, m_err});
      model_edge(x);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
